sync_updown_mod_counter: RTL and testbench
==========================================

Name: sync_updown_mod_counter

Overview:
- Modulo-N up counter: the counting-up counterpart to the team's 4-bit asynchronous down counter. Gives the counter library a clean up direction.
- Fully synchronous, single clock, so it can drive timing-critical logic that ripple counters cannot.
- Adds parallel load, a programmable modulus, a wrap/saturate mode, and a registered terminal-count pulse for cascading stages.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count sequence length; wrap occurs after MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, 0, 0 = wrap to 0 after MODULUS-1; 1 = hold at MODULUS-1.

Ports:
- clk  input  1  counter clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- t  input  1  count enable, toggle-enable semantics: 1 = advance, 0 = hold.
- load  input  1  synchronous parallel-load strobe.
- d  input  WIDTH  parallel-load value.
- cin  input  1  cascade carry-in; the count advances only when t & cin. Tie to 1 when unused.
- q  output  WIDTH  current count.
- q_bar  output  WIDTH  bitwise complement of q, always ~q.
- tc  output  1  terminal count, combinational: (q == MODULUS-1) & t & cin.
- wrap  output  1  registered one-cycle pulse after q wraps from MODULUS-1 to 0.
- sat  output  1  registered level, 1 while held at MODULUS-1 in SATURATE mode.

Behaviour:
- Reset (rst=0, asynchronous, immediate): q=0, q_bar=all ones, wrap=0, sat=0. tc=0 because q≠MODULUS-1.
- Release of rst is synchronised by the caller; the counter needs no internal synchroniser.
- Priority per rising edge: rst > load > count > hold.
- Load: when load=1, q <= d, independent of t and cin.
  - If d >= MODULUS, q <= d mod MODULUS. With MODULUS a power of two this is truncation to WIDTH bits.
  - Load clears sat and wrap on the same edge.
  - Load and count asserted in the same cycle: load wins; no increment and no wrap pulse.
- Count (load=0, t=1, cin=1):
  - q < MODULUS-1: q <= q+1.
  - q == MODULUS-1, SATURATE=0: q <= 0 and wrap <= 1 for exactly one cycle.
  - q == MODULUS-1, SATURATE=1: q holds, sat <= 1, wrap stays 0.
- Hold (t=0 or cin=0): q unchanged; wrap <= 0; sat keeps its value.
- Latency:
  - q updates one clock after the enabling edge.
  - tc is combinational, zero latency, for cascading into the next stage's cin.
  - wrap lags the wrap transition by 0 cycles: it is registered on the same edge that sets q=0.
- Arithmetic: unsigned; all internal compares use WIDTH bits; no X propagation from unused d bits.
- Reset mid-count: q clears immediately without waiting for clk. The count restarts at 0 on the first enabled edge after release, i.e. q=1 after that edge.
- Cascading: stage n+1 cin = stage n tc, with t tied to 1. Two 4-bit MODULUS=16 stages then form an 8-bit synchronous counter, and every bit changes on the same edge.

Test Plan:
- Reset/free-run: rst=0 for 12 ns, then t=1, cin=1 for 200 ns at a 10 ns period.
  - q steps 0,1,…,15,0,1,…
  - wrap is high for exactly one cycle each time q becomes 0 from 15.
  - q_bar == ~q at every sample.
- Enable hold: count to 7, set t=0 for 50 ns, then t=1.
  - q stays 7 throughout the hold; wrap stays 0; counting resumes 8,9,…
- Modulus/saturate: MODULUS=10, SATURATE=0 sequence is 0..9,0 with tc=1 only while q=9 and t=1. MODULUS=10, SATURATE=1 sticks at 9, sat=1, tc stays 1, wrap stays 0.
- Load priority: at q=5, assert load=1, d=4'hC, t=1.
  - Next q=12, not 6. No wrap on that edge.
  - With MODULUS=10, d=4'hC loads q=2.
- Async reset mid-count: drop rst at q=11 between clock edges.
  - q=0 within the same delta, before the next clk edge.
  - After release, the first enabled edge gives q=1.
- Cascade: two instances with tc→cin, t=1.
  - Combined count goes 8'h0F → 8'h10 on a single edge with no glitch cycle.
  - 8'hFF → 8'h00 produces a wrap pulse on the upper stage.

Source files
------------

// File: rtl/sync_updown_mod_counter.sv
// Synchronous modulo-N up counter with parallel load, wrap/saturate mode,
// combinational terminal count for cascading and registered wrap/sat flags.
module sync_updown_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             cin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  // One extra bit so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_sat;

  logic             w_adv;
  logic             w_at_max;
  logic [WIDTH-1:0] w_load_val;

  // Load value folded into the count range, plus advance/terminal decode.
  always_comb begin
    w_load_val = WIDTH'({1'b0, d} % MOD_EXT);
    w_adv      = t & cin;
    w_at_max   = (r_q == MAX_CNT);
  end

  // Count state: reset > load > count > hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= {WIDTH{1'b0}};
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else if (load) begin
      r_q    <= w_load_val;
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else if (w_adv) begin
      if (!w_at_max) begin
        r_q    <= r_q + {{(WIDTH-1){1'b0}}, 1'b1};
        r_wrap <= 1'b0;
        r_sat  <= 1'b0;
      end else if (SATURATE) begin
        r_q    <= r_q;
        r_wrap <= 1'b0;
        r_sat  <= 1'b1;
      end else begin
        r_q    <= {WIDTH{1'b0}};
        r_wrap <= 1'b1;
        r_sat  <= 1'b0;
      end
    end else begin
      r_q    <= r_q;
      r_wrap <= 1'b0;
      r_sat  <= r_sat;
    end
  end

  // tc stays combinational so a following stage's cin sees it on the same edge.
  always_comb begin
    q     = r_q;
    q_bar = ~r_q;
    tc    = w_at_max & w_adv;
    wrap  = r_wrap;
    sat   = r_sat;
  end

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
// Randomised and directed bench for sync_updown_mod_counter: three single
// instances (mod 16 wrap, mod 10 wrap, mod 10 saturate) and an 8-bit cascade.
module tb_sync_updown_mod_counter;

  logic clk;
  logic rst;

  logic       t_a   [3];
  logic       cin_a [3];
  logic       ld_a  [3];
  logic [3:0] d_a   [3];
  logic [3:0] q_a   [3];
  logic [3:0] qb_a  [3];
  logic       tc_a  [3];
  logic       wr_a  [3];
  logic       sat_a [3];

  logic       c_en, c_load;
  logic [3:0] c_d0, c_d1;
  logic [3:0] cq0, cq1, cqb0, cqb1;
  logic       ctc0, ctc1, cw0, cw1, cs0, cs1;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_q [3] = '{0, 0, 0};
  int m_w [3] = '{0, 0, 0};
  int m_s [3] = '{0, 0, 0};
  int cm  = 0;
  int cmw0 = 0;
  int cmw1 = 0;

  function automatic int mod_of(int i);
    return (i == 0) ? 16 : 10;
  endfunction

  function automatic int sat_of(int i);
    return (i == 2) ? 1 : 0;
  endfunction

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_m16 (
    .clk(clk), .rst(rst), .t(t_a[0]), .load(ld_a[0]), .d(d_a[0]), .cin(cin_a[0]),
    .q(q_a[0]), .q_bar(qb_a[0]), .tc(tc_a[0]), .wrap(wr_a[0]), .sat(sat_a[0]));

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_m10w (
    .clk(clk), .rst(rst), .t(t_a[1]), .load(ld_a[1]), .d(d_a[1]), .cin(cin_a[1]),
    .q(q_a[1]), .q_bar(qb_a[1]), .tc(tc_a[1]), .wrap(wr_a[1]), .sat(sat_a[1]));

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_m10s (
    .clk(clk), .rst(rst), .t(t_a[2]), .load(ld_a[2]), .d(d_a[2]), .cin(cin_a[2]),
    .q(q_a[2]), .q_bar(qb_a[2]), .tc(tc_a[2]), .wrap(wr_a[2]), .sat(sat_a[2]));

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_c0 (
    .clk(clk), .rst(rst), .t(1'b1), .load(c_load), .d(c_d0), .cin(c_en),
    .q(cq0), .q_bar(cqb0), .tc(ctc0), .wrap(cw0), .sat(cs0));

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .t(1'b1), .load(c_load), .d(c_d1), .cin(ctc0),
    .q(cq1), .q_bar(cqb1), .tc(ctc1), .wrap(cw1), .sat(cs1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic straight from the counting rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_q[i] <= 0;
        m_w[i] <= 0;
        m_s[i] <= 0;
      end
      cm   <= 0;
      cmw0 <= 0;
      cmw1 <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ld_a[i]) begin
          m_q[i] <= int'(d_a[i]) % mod_of(i);
          m_w[i] <= 0;
          m_s[i] <= 0;
        end else if (t_a[i] && cin_a[i]) begin
          if (m_q[i] < mod_of(i) - 1) begin
            m_q[i] <= m_q[i] + 1;
            m_w[i] <= 0;
          end else if (sat_of(i) == 1) begin
            m_s[i] <= 1;
            m_w[i] <= 0;
          end else begin
            m_q[i] <= 0;
            m_w[i] <= 1;
          end
        end else begin
          m_w[i] <= 0;
        end
      end
      if (c_load) begin
        cm   <= int'(c_d1) * 16 + int'(c_d0);
        cmw0 <= 0;
        cmw1 <= 0;
      end else if (c_en) begin
        cm   <= (cm + 1) % 256;
        cmw0 <= ((cm % 16) == 15) ? 1 : 0;
        cmw1 <= (cm == 255) ? 1 : 0;
      end else begin
        cmw0 <= 0;
        cmw1 <= 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q[%0d]", i), int'(q_a[i]), m_q[i]);
      chk($sformatf("q_bar[%0d]", i), int'(qb_a[i]), m_q[i] ^ 15);
      chk($sformatf("tc[%0d]", i), int'(tc_a[i]),
          ((m_q[i] == mod_of(i) - 1) && t_a[i] && cin_a[i]) ? 1 : 0);
      chk($sformatf("wrap[%0d]", i), int'(wr_a[i]), m_w[i]);
      chk($sformatf("sat[%0d]", i), int'(sat_a[i]), m_s[i]);
    end
    chk("casc_q", int'({cq1, cq0}), cm);
    chk("casc_qbar", int'({cqb1, cqb0}), cm ^ 255);
    chk("casc_tc0", int'(ctc0), (((cm % 16) == 15) && c_en) ? 1 : 0);
    chk("casc_tc1", int'(ctc1), ((cm == 255) && c_en) ? 1 : 0);
    chk("casc_wrap0", int'(cw0), cmw0);
    chk("casc_wrap1", int'(cw1), cmw1);
    chk("casc_sat", int'(cs0 | cs1), 0);
  end

  task automatic set_all(input logic t, input logic cin, input logic ld, input logic [3:0] d);
    for (int i = 0; i < 3; i++) begin
      t_a[i]   = t;
      cin_a[i] = cin;
      ld_a[i]  = ld;
      d_a[i]   = d;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set_all(1'b1, 1'b1, 1'b0, 4'd0);
    c_en = 1'b0; c_load = 1'b0; c_d0 = 4'd0; c_d1 = 4'd0;

    #2;
    chk("rst_q", int'(q_a[0]), 0);
    chk("rst_qbar", int'(qb_a[0]), 15);
    chk("rst_wrap", int'(wr_a[0]), 0);
    chk("rst_sat", int'(sat_a[2]), 0);
    chk("rst_tc", int'(tc_a[0]), 0);
    #10 rst = 1'b1;

    // Free run
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("run_q", int'(q_a[0]), k % 16);
      if (k == 9) begin
        chk("m10_tc_at9", int'(tc_a[1]), 1);
        chk("m10s_q9", int'(q_a[2]), 9);
      end
      if (k == 10) begin
        chk("m10_wrap0", int'(q_a[1]), 0);
        chk("m10_wrap_pulse", int'(wr_a[1]), 1);
        chk("m10s_sat", int'(sat_a[2]), 1);
      end
    end
    chk("run_wrap", int'(wr_a[0]), 1);
    chk("m10s_hold_q", int'(q_a[2]), 9);
    chk("m10s_tc", int'(tc_a[2]), 1);
    chk("m10s_nowrap", int'(wr_a[2]), 0);
    cyc();
    chk("run_q_after_wrap", int'(q_a[0]), 1);
    chk("run_wrap_clear", int'(wr_a[0]), 0);

    // Enable hold at 7
    repeat (6) cyc();
    chk("hold_start", int'(q_a[0]), 7);
    set_all(1'b0, 1'b1, 1'b0, 4'd0);
    repeat (5) begin
      cyc();
      chk("hold_q", int'(q_a[0]), 7);
      chk("hold_wrap", int'(wr_a[0]), 0);
    end
    set_all(1'b1, 1'b1, 1'b0, 4'd0);
    cyc();
    chk("resume_8", int'(q_a[0]), 8);
    cyc();
    chk("resume_9", int'(q_a[0]), 9);

    // Load priority over count
    set_all(1'b1, 1'b1, 1'b1, 4'd5);
    cyc();
    chk("load5", int'(q_a[0]), 5);
    set_all(1'b1, 1'b1, 1'b1, 4'hC);
    cyc();
    chk("loadC_m16", int'(q_a[0]), 12);
    chk("loadC_nowrap", int'(wr_a[0]), 0);
    chk("loadC_m10", int'(q_a[1]), 2);
    chk("loadC_m10s", int'(q_a[2]), 2);
    chk("loadC_satclr", int'(sat_a[2]), 0);
    set_all(1'b1, 1'b1, 1'b1, 4'd15);
    cyc();
    chk("load15", int'(q_a[0]), 15);
    set_all(1'b1, 1'b1, 1'b1, 4'd3);
    cyc();
    chk("load_at_max", int'(q_a[0]), 3);
    chk("load_at_max_nowrap", int'(wr_a[0]), 0);

    // Async reset mid-count at 11
    set_all(1'b1, 1'b1, 1'b1, 4'd9);
    cyc();
    set_all(1'b1, 1'b1, 1'b0, 4'd0);
    cyc();
    cyc();
    chk("pre_rst_11", int'(q_a[0]), 11);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_q", int'(q_a[0]), 0);
    chk("async_rst_qbar", int'(qb_a[0]), 15);
    cyc();
    chk("rst_held_q", int'(q_a[0]), 0);
    #1 rst = 1'b1;
    cyc();
    chk("first_after_rst", int'(q_a[0]), 1);

    // Cascade
    c_load = 1'b1; c_d0 = 4'hE; c_d1 = 4'h0; c_en = 1'b1;
    cyc();
    chk("casc_ld0E", int'({cq1, cq0}), 8'h0E);
    c_load = 1'b0;
    cyc();
    chk("casc_0F", int'({cq1, cq0}), 8'h0F);
    chk("casc_tc0_0F", int'(ctc0), 1);
    cyc();
    chk("casc_10", int'({cq1, cq0}), 8'h10);
    chk("casc_low_wrap", int'(cw0), 1);
    c_load = 1'b1; c_d0 = 4'hE; c_d1 = 4'hF;
    cyc();
    c_load = 1'b0;
    cyc();
    chk("casc_FF", int'({cq1, cq0}), 8'hFF);
    chk("casc_tc1_FF", int'(ctc1), 1);
    cyc();
    chk("casc_00", int'({cq1, cq0}), 8'h00);
    chk("casc_up_wrap", int'(cw1), 1);

    // Randomised phase
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (rst == 1'b0) rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
        t_a[i]   = ($urandom_range(0, 9) < 8);
        cin_a[i] = ($urandom_range(0, 9) < 8);
        ld_a[i]  = ($urandom_range(0, 19) == 0);
        d_a[i]   = 4'($urandom_range(0, 15));
      end
      c_en   = ($urandom_range(0, 9) < 9);
      c_load = ($urandom_range(0, 49) == 0);
      c_d0   = 4'($urandom_range(0, 15));
      c_d1   = 4'($urandom_range(0, 15));
      if (n == 1500) begin
        #2 rst = 1'b0;
      end
    end
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
